// File: rtl/sr_frame_capture_if.sv
// Serial register-load link plus the parallel capture results.
// master: the side that drives the serial stream (control FSM / bench).
// slave:  the capture block.
interface sr_frame_capture_if #(
  parameter int unsigned SIZESRSTAT = 88,
  parameter int unsigned SIZESRDYN  = 16
);
  logic                  SEL;
  logic                  SCLK;
  logic                  MOSI;
  logic [SIZESRDYN-1:0]  DYN_Q;
  logic                  DYN_VALID;
  logic [SIZESRSTAT-1:0] STAT_Q;
  logic                  STAT_VALID;
  logic                  FRAME_ERR;
  logic                  BUSY;

  modport master (
    output SEL, SCLK, MOSI,
    input  DYN_Q, DYN_VALID, STAT_Q, STAT_VALID, FRAME_ERR, BUSY
  );

  modport slave (
    input  SEL, SCLK, MOSI,
    output DYN_Q, DYN_VALID, STAT_Q, STAT_VALID, FRAME_ERR, BUSY
  );
endinterface

// File: rtl/sr_frame_capture.sv
// Receive side of the register-loading link. Resynchronises SEL/SCLK/MOSI,
// rebuilds the dynamic and static words and flags malformed or stalled frames.
module sr_frame_capture #(
  parameter int unsigned SIZESRSTAT     = 88,
  parameter int unsigned SIZESRDYN      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                CLK,
  input logic                RST,
  sr_frame_capture_if.slave  bus
);

  localparam int unsigned DynCntW  = $clog2(SIZESRDYN + 2);
  localparam int unsigned StatCntW = $clog2(SIZESRSTAT + 2);
  localparam int unsigned IdleW    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [DynCntW-1:0]  DynFull  = DynCntW'(SIZESRDYN);
  localparam logic [DynCntW-1:0]  DynSat   = DynCntW'(SIZESRDYN + 1);
  localparam logic [StatCntW-1:0] StatFull = StatCntW'(SIZESRSTAT);
  localparam logic [IdleW-1:0]    IdleMax  = IdleW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StDynShift, StStatShift} state_e;

  state_e                state;
  logic [2:0]            sel_sync;
  logic [2:0]            sclk_sync;
  logic [1:0]            mosi_sync;
  logic [DynCntW-1:0]    dyn_cnt;
  logic [StatCntW-1:0]   stat_cnt;
  logic [IdleW-1:0]      idle_cnt;
  logic [SIZESRDYN-1:0]  dyn_shadow;
  logic [SIZESRSTAT-1:0] stat_shadow;

  logic                  sel_s2, mosi_s2;
  logic                  sclk_rise, sel_rise, sel_fall;
  logic [SIZESRDYN-1:0]  dyn_shifted;
  logic [SIZESRSTAT-1:0] stat_shifted;
  logic [IdleW-1:0]      idle_next;

  // Two sync stages plus one history stage; reset values avoid a fake edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sel_sync  <= 3'b111;
      sclk_sync <= 3'b000;
      mosi_sync <= 2'b00;
    end else begin
      sel_sync  <= {sel_sync[1:0], bus.SEL};
      sclk_sync <= {sclk_sync[1:0], bus.SCLK};
      mosi_sync <= {mosi_sync[0], bus.MOSI};
    end
  end

  assign sel_s2       = sel_sync[1];
  assign mosi_s2      = mosi_sync[1];
  assign sclk_rise    = sclk_sync[1] & ~sclk_sync[2];
  assign sel_rise     = sel_sync[1] & ~sel_sync[2];
  assign sel_fall     = ~sel_sync[1] & sel_sync[2];
  assign dyn_shifted  = {dyn_shadow[SIZESRDYN-2:0], mosi_s2};
  assign stat_shifted = {stat_shadow[SIZESRSTAT-2:0], mosi_s2};
  assign idle_next    = idle_cnt + 1'b1;
  assign bus.BUSY     = (state != StIdle);

  // Frame FSM; all outputs are registered here and pulses default low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state          <= StIdle;
      dyn_cnt        <= '0;
      stat_cnt       <= '0;
      idle_cnt       <= '0;
      dyn_shadow     <= '0;
      stat_shadow    <= '0;
      bus.DYN_Q      <= '0;
      bus.STAT_Q     <= '0;
      bus.DYN_VALID  <= 1'b0;
      bus.STAT_VALID <= 1'b0;
      bus.FRAME_ERR  <= 1'b0;
    end else begin
      bus.DYN_VALID  <= 1'b0;
      bus.STAT_VALID <= 1'b0;
      bus.FRAME_ERR  <= 1'b0;
      unique case (state)
        StIdle: begin
          idle_cnt <= '0;
          if (sel_fall) begin
            // A coincident SCLK edge is the first dynamic bit.
            state <= StDynShift;
            if (sclk_rise) begin
              dyn_shadow <= dyn_shifted;
              dyn_cnt    <= DynCntW'(1);
            end else begin
              dyn_cnt <= '0;
            end
          end else if (sclk_rise && sel_s2) begin
            stat_shadow <= stat_shifted;
            stat_cnt    <= StatCntW'(1);
            state       <= StStatShift;
          end
        end

        StDynShift: begin
          if (sel_rise) begin
            // Close on the count before any coincident SCLK edge.
            if (dyn_cnt == DynFull) begin
              bus.DYN_Q     <= dyn_shadow;
              bus.DYN_VALID <= 1'b1;
            end else begin
              bus.FRAME_ERR <= 1'b1;
            end
            idle_cnt <= '0;
            if (sclk_rise) begin
              stat_shadow <= stat_shifted;
              stat_cnt    <= StatCntW'(1);
              state       <= StStatShift;
            end else begin
              state <= StIdle;
            end
          end else if (sclk_rise) begin
            dyn_shadow <= dyn_shifted;
            idle_cnt   <= '0;
            if (dyn_cnt != DynSat) dyn_cnt <= dyn_cnt + 1'b1;
          end else if (idle_next == IdleMax) begin
            bus.FRAME_ERR <= 1'b1;
            idle_cnt      <= '0;
            state         <= StIdle;
          end else begin
            idle_cnt <= idle_next;
          end
        end

        StStatShift: begin
          if (sel_fall) begin
            bus.FRAME_ERR <= 1'b1;
            stat_cnt      <= '0;
            dyn_cnt       <= '0;
            idle_cnt      <= '0;
            state         <= StDynShift;
          end else if (sclk_rise) begin
            idle_cnt <= '0;
            if (stat_cnt + 1'b1 == StatFull) begin
              bus.STAT_Q     <= stat_shifted;
              bus.STAT_VALID <= 1'b1;
              stat_shadow    <= stat_shifted;
              stat_cnt       <= '0;
              state          <= StIdle;
            end else begin
              stat_shadow <= stat_shifted;
              stat_cnt    <= stat_cnt + 1'b1;
            end
          end else if (idle_next == IdleMax) begin
            bus.FRAME_ERR <= 1'b1;
            idle_cnt      <= '0;
            stat_cnt      <= '0;
            state         <= StIdle;
          end else begin
            idle_cnt <= idle_next;
          end
        end

        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/sr_frame_capture.md
Name: sr_frame_capture

Overview:
- Receive side of the register-loading link. Sits directly downstream of the register-load control FSM and consumes its SEL / SCLK / MOSI stream.
- Rebuilds the 16-bit dynamic word and the 88-bit static word and presents each as a parallel register with a one-cycle valid strobe.
- Flags framing faults: wrong bit count, SEL toggling mid-frame, or a stalled SCLK.

Parameters:
SIZESRSTAT, 88, static word length in bits
SIZESRDYN, 16, dynamic word length in bits
TIMEOUT_CYCLES, 255, CLK cycles without an SCLK rising edge before an open frame is aborted

Ports:
CLK  input  1  system clock
RST  input  1  synchronous reset, active-high
SEL  input  1  frame select: 0 = dynamic frame, 1 = static frame/idle
SCLK  input  1  serial bit clock; data captured on rising edge
MOSI  input  1  serial data, MSB first
DYN_Q  output  SIZESRDYN  last complete dynamic word
DYN_VALID  output  1  one-cycle pulse when DYN_Q updates
STAT_Q  output  SIZESRSTAT  last complete static word
STAT_VALID  output  1  one-cycle pulse when STAT_Q updates
FRAME_ERR  output  1  one-cycle pulse on an aborted/malformed frame
BUSY  output  1  high while state != IDLE

Behaviour:
- Input conditioning:
  - SEL, SCLK and MOSI each pass through 2 sync flops plus 1 history flop.
  - Sync-chain reset values: SEL=1, SCLK=0, MOSI=0, so no spurious edge appears after reset.
  - sclk_rise = s2 & ~s3; sel_fall / sel_rise are defined the same way on SEL.
  - An input sampled at edge e0 acts at edge e2; the matching VALID/ERR pulse is high during the cycle after e2.
- Shifting: MSB first. shadow <= {shadow[N-2:0], MOSI_s2} on sclk_rise.
- Reset (RST=1 at a CLK edge, including mid-frame):
  - DYN_Q=0, STAT_Q=0, DYN_VALID=0, STAT_VALID=0, FRAME_ERR=0, BUSY=0.
  - State=IDLE; counters and shadows cleared; any partial frame is discarded.
- States: IDLE, DYN_SHIFT, STAT_SHIFT.
- IDLE:
  - sel_fall -> DYN_SHIFT, dyn_cnt=0.
  - sclk_rise with SEL_s2=1 -> shift into stat shadow, stat_cnt=1, go to STAT_SHIFT.
  - sel_fall wins if both occur in the same cycle; that edge is then the first dynamic bit.
- DYN_SHIFT:
  - sclk_rise: shift dyn shadow; dyn_cnt++ saturating at SIZESRDYN+1, which marks overflow.
  - sel_rise with dyn_cnt==SIZESRDYN: DYN_Q<=shadow, DYN_VALID pulse, go to IDLE.
  - sel_rise with any other count: FRAME_ERR pulse, DYN_Q unchanged, go to IDLE.
  - sel_rise and sclk_rise in the same cycle: close the dynamic frame using the count before this edge. The edge counts as static bit 1 (stat_cnt=1), go to STAT_SHIFT.
- STAT_SHIFT:
  - sclk_rise: shift, stat_cnt++.
  - When this edge brings stat_cnt to SIZESRSTAT: STAT_Q<=shifted value including this bit, STAT_VALID pulse, stat_cnt=0, go to IDLE.
  - sel_fall: FRAME_ERR pulse, discard the static partial, go to DYN_SHIFT with dyn_cnt=0.
- Timeout (DYN_SHIFT and STAT_SHIFT only):
  - idle_cnt clears on every sclk_rise and on state entry; otherwise increments.
  - On reaching TIMEOUT_CYCLES: FRAME_ERR pulse, go to IDLE, Q outputs unchanged.
  - No timeout in IDLE.
- DYN_Q/STAT_Q hold their value until the next valid frame. VALID and ERR are never asserted in the same cycle.
- Counter widths are $clog2(N+2); idle_cnt width is $clog2(TIMEOUT_CYCLES+1).

Test Plan:
- Reset, then SEL low, 16 SCLK pulses carrying 0xABCD MSB first, SEL high -> DYN_Q=16'hABCD, DYN_VALID high exactly 1 cycle, FRAME_ERR stays 0.
- With SEL high, 88 SCLK pulses of 88'h123456789ABCDEF1234567 -> STAT_Q=that value, one STAT_VALID pulse after the 88th edge, BUSY returns 0.
- Dynamic frame of 15 edges, then a separate frame of 17 edges, each closed by SEL rise -> FRAME_ERR pulses twice, DYN_Q keeps the prior 0xABCD.
- Static frame stopped after 40 edges, SCLK held low 255 cycles -> one FRAME_ERR pulse, state IDLE; a following full 88-bit frame is captured correctly.
- SEL falls after 50 static edges -> FRAME_ERR, then a 16-edge dynamic frame of 0x1234 -> DYN_Q=16'h1234.
- RST asserted mid-dynamic frame at edge 8 -> all outputs 0 the next cycle; a following clean 0x5A5A frame -> DYN_Q=16'h5A5A.
